control_fsm: RTL
================

Name: control_fsm

Overview:
- Multi-cycle RISC-V (RV32I subset) control unit: the producer side of the ALU interface.
- Sequences lw, sw, R-type, I-type ALU, beq and jal through per-instruction state paths.
- Drives the ALU operation code (pa_riscv enum: ADD, SUB, SLT, AND, OR, XOR), datapath mux selects and write enables.
- Consumes the ALU zero flag to resolve beq.

Parameters:
- None; opcode, funct and ALU encodings come from pa_riscv.

Ports:
- i_clk  input  1  clock; all state changes on rising edge
- i_arst_n  input  1  asynchronous active-low reset
- i_op  input  7  instruction opcode (instr[6:0]); valid from DECODE onward
- i_funct3  input  3  instr[14:12]
- i_funct7b5  input  1  instr[30]
- i_zeroFlag  input  1  ALU zero flag, same cycle as o_aluLogicOperation
- o_pcWrite  output  1  PC register enable
- o_adrSrc  output  1  memory address: 0=PC, 1=ALU result register
- o_memWrite  output  1  data memory write enable
- o_irWrite  output  1  instruction/oldPC register enable
- o_resultSrc  output  2  result mux: 00=ALUOut, 01=read data, 10=ALU result
- o_aluSrcA  output  2  00=PC, 01=oldPC, 10=rs1 register
- o_aluSrcB  output  2  00=rs2 register, 01=immediate, 10=constant 4
- o_aluLogicOperation  output  4  ALU operation (pa_riscv enum)
- o_immSrc  output  2  00=I, 01=S, 10=B, 11=J
- o_regWrite  output  1  register file write enable
- o_illegal  output  1  one-cycle pulse on an unsupported opcode or funct3

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL.
- Reset: state=FETCH. While i_arst_n=0, pcWrite, irWrite, regWrite, memWrite and illegal are forced to 0; all other outputs take FETCH values.
- Mid-instruction reset: abandons the instruction, with no further writes.

Transitions:
- FETCH->DECODE.
- DECODE dispatch: lw/sw->MEMADR; R->EXECUTER; I-ALU->EXECUTEI; jal->JAL; beq->BEQ; any other opcode->FETCH with o_illegal=1 for that cycle.
- MEMADR: lw->MEMREAD, sw->MEMWRITE.
- MEMREAD->MEMWB->FETCH.
- MEMWRITE->FETCH.
- EXECUTER and EXECUTEI->ALUWB->FETCH.
- JAL->ALUWB.
- BEQ->FETCH.

Moore outputs (unlisted signals 0 / 00):
- FETCH: adrSrc=0, irWrite=1, aluSrcA=00, aluSrcB=10, aluOp=00, resultSrc=10, pcUpdate=1.
- DECODE: aluSrcA=01, aluSrcB=01, aluOp=00 (branch/jump target).
- MEMADR: aluSrcA=10, aluSrcB=01, aluOp=00.
- MEMREAD: adrSrc=1, resultSrc=00.
- MEMWB: resultSrc=01, regWrite=1.
- MEMWRITE: adrSrc=1, memWrite=1.
- EXECUTER: aluSrcA=10, aluSrcB=00, aluOp=10.
- EXECUTEI: aluSrcA=10, aluSrcB=01, aluOp=10.
- ALUWB: resultSrc=00, regWrite=1.
- BEQ: aluSrcA=10, aluSrcB=00, aluOp=01, resultSrc=00, branch=1.
- JAL: aluSrcA=01, aluSrcB=10, aluOp=00, resultSrc=00, pcUpdate=1.

Write-enable and immediate logic:
- o_pcWrite = pcUpdate | (branch & i_zeroFlag); combinational on i_zeroFlag in BEQ.
- o_immSrc is combinational from i_op: lw/I-ALU=00, sw=01, beq=10, jal=11, others=00.

ALU decode (combinational):
- aluOp=00 -> ADD; aluOp=01 -> SUB.
- aluOp=10, funct3=000: SUB only if R-type and i_funct7b5=1, else ADD (addi ignores funct7b5).
- aluOp=10, funct3 010->SLT, 100->XOR, 110->OR, 111->AND.
- Any other funct3 under aluOp=10 -> ADD, and o_illegal=1 in that EXECUTE state; the instruction still completes through ALUWB.

Latency (cycles, FETCH through last state):
- lw 5; sw 4; R 4; I 4; jal 4; beq 3; illegal 2.
- Every instruction returns to FETCH; there is no stall input.

Test Plan:
- Reset, release, op=0000011 (lw): states FETCH,DECODE,MEMADR,MEMREAD,MEMWB,FETCH; irWrite=1 in cycle 0 only, regWrite=1 in cycle 4 only, immSrc=00, memWrite never 1.
- op=0110011, funct3=000, funct7b5=1 -> SUB in EXECUTER; funct7b5=0 -> ADD. op=0010011, funct3=000, funct7b5=1 -> ADD. funct3 010/100/110/111 -> SLT/XOR/OR/AND.
- op=1100011 with i_zeroFlag=1 in BEQ -> pcWrite=1, aluOp=SUB, immSrc=10; with i_zeroFlag=0 -> pcWrite=0; next state FETCH in both cases.
- op=0100011 (sw): memWrite=1 and adrSrc=1 in cycle 3 only, immSrc=01, regWrite never 1; op=1101111 (jal): pcWrite=1 in JAL, regWrite=1 in ALUWB.
- op=1111111: o_illegal=1 for exactly the DECODE cycle, next state FETCH, no write enable asserted.
- Assert i_arst_n=0 mid-MEMADR (asynchronously, between edges): outputs immediately show FETCH values with all write enables 0; after release, irWrite=1 on the first cycle.

Source files
------------

// File: rtl/control_fsm_if.sv
// Control/datapath boundary of the multi-cycle RV32I core: instruction fields and ALU zero flag in,
// mux selects, ALU operation and write enables out. master = control unit, slave = datapath.
interface control_fsm_if;
    logic [6:0] i_op;
    logic [2:0] i_funct3;
    logic       i_funct7b5;
    logic       i_zeroFlag;
    logic       o_pcWrite;
    logic       o_adrSrc;
    logic       o_memWrite;
    logic       o_irWrite;
    logic [1:0] o_resultSrc;
    logic [1:0] o_aluSrcA;
    logic [1:0] o_aluSrcB;
    logic [3:0] o_aluLogicOperation;
    logic [1:0] o_immSrc;
    logic       o_regWrite;
    logic       o_illegal;

    modport master (
        input  i_op, i_funct3, i_funct7b5, i_zeroFlag,
        output o_pcWrite, o_adrSrc, o_memWrite, o_irWrite, o_resultSrc, o_aluSrcA,
               o_aluSrcB, o_aluLogicOperation, o_immSrc, o_regWrite, o_illegal
    );

    modport slave (
        output i_op, i_funct3, i_funct7b5, i_zeroFlag,
        input  o_pcWrite, o_adrSrc, o_memWrite, o_irWrite, o_resultSrc, o_aluSrcA,
               o_aluSrcB, o_aluLogicOperation, o_immSrc, o_regWrite, o_illegal
    );
endinterface

// File: rtl/control_fsm.sv
// Multi-cycle RV32I control unit (lw, sw, R, I-ALU, beq, jal); Moore state outputs plus combinational ALU/imm decode.
// Latency lw 5, sw/R/I/jal 4, beq 3, illegal 2 cycles; no stall input, every instruction returns to FETCH.
package pa_riscv;
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_SLT = 4'd2,
        ALU_AND = 4'd3,
        ALU_OR  = 4'd4,
        ALU_XOR = 4'd5
    } alu_op_e;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
endpackage

module control_fsm
    import pa_riscv::*;
(
    input  logic           i_clk,
    input  logic           i_arst_n,
    control_fsm_if.master  ctl
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL
    } state_e;

    state_e     state_q, state_d;
    logic       pc_update, branch, adr_src, mem_write, ir_write, reg_write, illegal_op;
    logic [1:0] result_src, src_a, src_b, alu_op;
    alu_op_e    alu_sel;
    logic       funct_bad;
    logic [1:0] imm_src;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) state_q <= S_FETCH;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        pc_update  = 1'b0;
        branch     = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        illegal_op = 1'b0;
        result_src = 2'b00;
        src_a      = 2'b00;
        src_b      = 2'b00;
        alu_op     = 2'b00;
        case (state_q)
            S_FETCH: begin
                ir_write   = 1'b1;
                src_b      = 2'b10;
                result_src = 2'b10;
                pc_update  = 1'b1;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                // DECODE precomputes the branch/jump target from oldPC + imm
                src_a = 2'b01;
                src_b = 2'b01;
                case (ctl.i_op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default: begin
                        state_d    = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                src_a   = 2'b10;
                src_b   = 2'b01;
                state_d = (ctl.i_op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_EXECUTER: begin
                src_a   = 2'b10;
                alu_op  = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECUTEI: begin
                src_a   = 2'b10;
                src_b   = 2'b01;
                alu_op  = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BEQ: begin
                src_a   = 2'b10;
                alu_op  = 2'b01;
                branch  = 1'b1;
                state_d = S_FETCH;
            end
            S_JAL: begin
                src_a     = 2'b01;
                src_b     = 2'b10;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Unknown funct3 still executes as ADD and retires; it is only flagged
    always_comb begin
        alu_sel   = ALU_ADD;
        funct_bad = 1'b0;
        case (alu_op)
            2'b01: alu_sel = ALU_SUB;
            2'b10: begin
                case (ctl.i_funct3)
                    F3_ADD:  alu_sel = (ctl.i_op == OP_R && ctl.i_funct7b5) ? ALU_SUB : ALU_ADD;
                    F3_SLT:  alu_sel = ALU_SLT;
                    F3_XOR:  alu_sel = ALU_XOR;
                    F3_OR:   alu_sel = ALU_OR;
                    F3_AND:  alu_sel = ALU_AND;
                    default: funct_bad = 1'b1;
                endcase
            end
            default: alu_sel = ALU_ADD;
        endcase
    end

    always_comb begin
        imm_src = 2'b00;
        case (ctl.i_op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    // Write enables are gated by reset directly so nothing commits while reset is held
    assign ctl.o_pcWrite           = i_arst_n & (pc_update | (branch & ctl.i_zeroFlag));
    assign ctl.o_irWrite           = i_arst_n & ir_write;
    assign ctl.o_regWrite          = i_arst_n & reg_write;
    assign ctl.o_memWrite          = i_arst_n & mem_write;
    assign ctl.o_illegal           = i_arst_n & (illegal_op | funct_bad);
    assign ctl.o_adrSrc            = adr_src;
    assign ctl.o_resultSrc         = result_src;
    assign ctl.o_aluSrcA           = src_a;
    assign ctl.o_aluSrcB           = src_b;
    assign ctl.o_aluLogicOperation = alu_sel;
    assign ctl.o_immSrc            = imm_src;
endmodule
